// File: rtl/seq_stepper_if.sv
// Control, table-write and observation signals of the sequence stepper.
// The stepper itself attaches through the slave modport; whatever drives it uses master.
interface seq_stepper_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             CE;
  logic [1:0]       MODE;
  logic             STEP;
  logic [AW-1:0]    LAST;
  logic             WR_EN;
  logic [AW-1:0]    WR_ADDR;
  logic [WIDTH-1:0] WR_DATA;
  logic [WIDTH-1:0] VAL;
  logic [AW-1:0]    IDX;
  logic [WIDTH-1:0] LOG_LOGIC;
  logic [WIDTH-1:0] LOG_SWITCHING;
  logic             WRAP;

  modport master (
    output CE, MODE, STEP, LAST, WR_EN, WR_ADDR, WR_DATA,
    input  VAL, IDX, LOG_LOGIC, LOG_SWITCHING, WRAP
  );

  modport slave (
    input  CE, MODE, STEP, LAST, WR_EN, WR_ADDR, WR_DATA,
    output VAL, IDX, LOG_LOGIC, LOG_SWITCHING, WRAP
  );
endinterface

// File: rtl/seq_stepper.sv
// Table-driven sequence stepper: walks a writable value table forward, in reverse,
// or one entry per STEP rising edge, with a one-cycle WRAP pulse on each wrap.
module seq_stepper #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic          C1K,
  input logic          RST,
  seq_stepper_if.slave bus
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];

  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             wrap_q, wrap_d;
  logic             step_dly_q, step_dly_d;

  logic [AW-1:0]    next_idx;
  logic             fwd_wrap, rev_wrap, wrap_cond;
  logic             step_rise, adv;
  logic [WIDTH-1:0] log_logic;

  always_comb begin
    fwd_wrap  = (idx_q >= bus.LAST);
    // Reverse also wraps when LAST was lowered below the current index.
    rev_wrap  = (idx_q == '0) || (idx_q > bus.LAST);
    step_rise = bus.STEP & ~step_dly_q;
    next_idx  = idx_q;
    wrap_cond = 1'b0;
    adv       = 1'b0;
    unique case (bus.MODE)
      MODE_FWD: begin
        next_idx  = fwd_wrap ? '0 : idx_q + AW'(1);
        wrap_cond = fwd_wrap;
        adv       = bus.CE;
      end
      MODE_REV: begin
        next_idx  = rev_wrap ? bus.LAST : idx_q - AW'(1);
        wrap_cond = rev_wrap;
        adv       = bus.CE;
      end
      MODE_STEP: begin
        next_idx  = fwd_wrap ? '0 : idx_q + AW'(1);
        wrap_cond = fwd_wrap;
        adv       = bus.CE & step_rise;
      end
      MODE_HOLD: begin
        next_idx  = idx_q;
      end
      default: begin
        next_idx  = idx_q;
      end
    endcase
  end

  // Read comes from the pre-write table, so a same-edge write to next_idx loads the old entry.
  always_comb begin
    log_logic  = table_q[next_idx];
    idx_d      = adv ? next_idx  : idx_q;
    val_d      = adv ? log_logic : val_q;
    wrap_d     = adv & wrap_cond;
    step_dly_d = bus.STEP;
    for (int i = 0; i < DEPTH; i++) begin
      table_d[i] = table_q[i];
    end
    if (bus.WR_EN) begin
      table_d[bus.WR_ADDR] = bus.WR_DATA;
    end
  end

  always_ff @(posedge C1K) begin
    if (RST) begin
      idx_q      <= '0;
      val_q      <= '0;
      wrap_q     <= 1'b0;
      step_dly_q <= 1'b0;
      // Identity contents make a freshly reset forward walk a plain binary counter.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(i);
      end
    end else begin
      idx_q      <= idx_d;
      val_q      <= val_d;
      wrap_q     <= wrap_d;
      step_dly_q <= step_dly_d;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign bus.VAL           = val_q;
  assign bus.IDX           = idx_q;
  assign bus.WRAP          = wrap_q;
  assign bus.LOG_LOGIC     = log_logic;
  assign bus.LOG_SWITCHING = adv ? log_logic : val_q;

endmodule

// File: tb/tb_seq_stepper.sv
// Self-checking bench for seq_stepper: directed scenarios followed by random traffic,
// all compared against a behavioural table/index model.
module tb_seq_stepper;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int VMOD  = 1 << WIDTH;

  logic C1K = 1'b0;
  logic RST;

  seq_stepper_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  seq_stepper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .C1K (C1K),
    .RST (RST),
    .bus (bus)
  );

  always #5 C1K = ~C1K;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference state
  int  tbl [DEPTH];
  int  m_idx, m_val, m_wrap, m_step;
  bit  m_ok = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_next(input int mode, input int idx, input int last);
    if (mode == 0) return idx;
    if (mode == 2) return (idx == 0 || idx > last) ? last : idx - 1;
    return (idx >= last) ? 0 : idx + 1;
  endfunction

  function automatic int ref_wraps(input int mode, input int idx, input int last);
    if (mode == 0) return 0;
    if (mode == 2) return (idx == 0 || idx > last) ? 1 : 0;
    return (idx >= last) ? 1 : 0;
  endfunction

  // One clock: combinational outputs checked mid-cycle, registered ones just after the edge.
  task automatic tick();
    int mode, last, n, a, w;
    @(negedge C1K);
    mode = int'(bus.MODE);
    last = int'(bus.LAST);
    n    = ref_next(mode, m_idx, last);
    w    = ref_wraps(mode, m_idx, last);
    a    = (bus.CE && (mode == 1 || mode == 2 || (mode == 3 && bus.STEP && !m_step))) ? 1 : 0;
    if (m_ok) begin
      check("log_logic", int'(bus.LOG_LOGIC), tbl[n]);
      check("log_switching", int'(bus.LOG_SWITCHING), a ? tbl[n] : m_val);
    end
    @(posedge C1K);
    if (RST) begin
      m_idx = 0; m_val = 0; m_wrap = 0; m_step = 0;
      for (int i = 0; i < DEPTH; i++) tbl[i] = i % VMOD;
    end else begin
      if (a) begin
        m_val = tbl[n];
        m_idx = n;
      end
      m_wrap = a & w;
      m_step = int'(bus.STEP);
      if (bus.WR_EN) tbl[int'(bus.WR_ADDR)] = int'(bus.WR_DATA);
    end
    m_ok = 1'b1;
    #1;
    cyc++;
    check("idx", int'(bus.IDX), m_idx);
    check("val", int'(bus.VAL), m_val);
    check("wrap", int'(bus.WRAP), m_wrap);
    $display("cyc %0d rst=%0d ce=%0d mode=%0d step=%0d last=%0d we=%0d -> idx=%0d val=%0d wrap=%0d",
             cyc, RST, bus.CE, bus.MODE, bus.STEP, bus.LAST, bus.WR_EN,
             bus.IDX, bus.VAL, bus.WRAP);
  endtask

  initial begin
    int exp_val [4];
    int exp_rev_idx [5];
    int exp_rev_wrap [5];
    exp_val      = '{7, 6, 5, 0};
    exp_rev_idx  = '{3, 2, 1, 0, 3};
    exp_rev_wrap = '{1, 0, 0, 0, 1};

    RST = 1'b1;
    bus.CE = 1'b0; bus.MODE = 2'b00; bus.STEP = 1'b0; bus.LAST = 4'd15;
    bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
    tick();
    tick();
    check("rst_idx", int'(bus.IDX), 0);
    check("rst_val", int'(bus.VAL), 0);
    check("rst_wrap", int'(bus.WRAP), 0);

    // Default table, forward: binary up-count 0..15,0 with WRAP only on return to 0
    RST = 1'b0; bus.CE = 1'b1; bus.MODE = 2'b01; bus.LAST = 4'd15;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("count_val", int'(bus.VAL), k % 16);
      check("count_wrap", int'(bus.WRAP), (k == 16) ? 1 : 0);
    end

    // Load 0,7,6,5 while holding, then cycle with LAST=3
    bus.CE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.WR_EN = 1'b1; bus.WR_ADDR = 4'(k); bus.WR_DATA = 4'(exp_val[(k + 3) % 4]);
      tick();
    end
    bus.WR_EN = 1'b0; bus.LAST = 4'd3; bus.CE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("tbl_seq_val", int'(bus.VAL), exp_val[k % 4]);
    end

    // Hold at VAL=6
    tick();
    tick();
    check("pre_hold_val", int'(bus.VAL), 6);
    bus.CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_val", int'(bus.VAL), 6);
      check("hold_idx", int'(bus.IDX), 2);
      check("hold_sw", int'(bus.LOG_SWITCHING), 6);
      check("hold_ll", int'(bus.LOG_LOGIC), 5);
    end

    // Reverse from IDX=0
    bus.CE = 1'b1;
    tick();
    tick();
    check("pre_rev_idx", int'(bus.IDX), 0);
    bus.MODE = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rev_idx", int'(bus.IDX), exp_rev_idx[k]);
      check("rev_wrap", int'(bus.WRAP), exp_rev_wrap[k]);
    end

    // Single-step: STEP held high advances once, a later pulse once more
    bus.MODE = 2'b11; bus.STEP = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("step_held_idx", int'(bus.IDX), 0);
    bus.STEP = 1'b0; tick();
    bus.STEP = 1'b1; tick();
    bus.STEP = 1'b0; tick();
    check("step_pulse_idx", int'(bus.IDX), 1);

    // Reset beats a concurrent write
    bus.MODE = 2'b01;
    tick();
    RST = 1'b1; bus.WR_EN = 1'b1; bus.WR_ADDR = 4'd2; bus.WR_DATA = 4'd9;
    tick();
    check("rstwr_idx", int'(bus.IDX), 0);
    check("rstwr_val", int'(bus.VAL), 0);
    check("rstwr_wrap", int'(bus.WRAP), 0);
    RST = 1'b0; bus.WR_EN = 1'b0; bus.LAST = 4'd15;
    tick();
    tick();
    check("rstwr_tbl2", int'(bus.VAL), 2);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      RST         = ($urandom_range(0, 99) < 2);
      bus.CE      = ($urandom_range(0, 9) != 0);
      bus.MODE    = 2'($urandom_range(0, 3));
      bus.STEP    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.LAST = 4'($urandom_range(0, DEPTH - 1));
      bus.WR_EN   = ($urandom_range(0, 3) == 0);
      bus.WR_ADDR = 4'($urandom_range(0, DEPTH - 1));
      bus.WR_DATA = 4'($urandom_range(0, VMOD - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_stepper.md
SEQ_STEPPER -- requirements
Module: seq_stepper

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: bit width of each sequence value.
REQ-002 SHALL provide parameter DEPTH, default 16: number of sequence-table entries; power of two, at least 2.
REQ-003 SHALL provide derived parameter AW = clog2(DEPTH): index width.
REQ-004 SHALL provide port C1K  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide port CE  input  1  count enable; 0 holds state.
REQ-007 SHALL provide port MODE  input  2  00 hold, 01 forward, 10 reverse, 11 single-step.
REQ-008 SHALL provide port STEP  input  1  step request, honoured only in MODE 11.
REQ-009 SHALL provide port LAST  input  AW  highest table index in the active sequence.
REQ-010 SHALL provide port WR_EN  input  1  table write strobe.
REQ-011 SHALL provide port WR_ADDR  input  AW  table write index.
REQ-012 SHALL provide port WR_DATA  input  WIDTH  table write value.
REQ-013 SHALL provide port VAL  output  WIDTH  registered current sequence value.
REQ-014 SHALL provide port IDX  output  AW  registered current table index.
REQ-015 SHALL provide port LOG_LOGIC  output  WIDTH  combinational candidate next value, table[next_idx].
REQ-016 SHALL provide port LOG_SWITCHING  output  WIDTH  combinational value to be loaded: LOG_LOGIC if adv=1, else VAL.
REQ-017 SHALL provide port WRAP  output  1  registered one-cycle pulse on sequence wrap.

Function
REQ-018 SHALL hold a DEPTH x WIDTH register table.
REQ-019 SHALL write table[WR_ADDR] <= WR_DATA on a clock edge with WR_EN=1 and RST=0.
REQ-020 SHALL compute next_idx forward as 0 when IDX >= LAST, else IDX+1.
REQ-021 SHALL compute next_idx reverse as LAST when IDX == 0 or IDX > LAST, else IDX-1.
REQ-022 SHALL use the forward rule for MODE 11; for MODE 00, next_idx = IDX.
REQ-023 SHALL register STEP each cycle as step_d; step_rise = STEP & ~step_d.
REQ-024 SHALL set adv = CE & (MODE==01 | MODE==10 | (MODE==11 & step_rise)).
REQ-025 SHALL, when adv=1, load IDX <= next_idx and VAL <= LOG_LOGIC on the same edge (latency 1 cycle); when adv=0, IDX and VAL hold.
REQ-026 SHALL set WRAP=1 for exactly the cycle following an advance where forward IDX >= LAST, or reverse IDX == 0 or IDX > LAST; otherwise WRAP=0.
REQ-027 SHALL read the table pre-write: a same-cycle write to table[next_idx] loads the old entry into VAL; the new entry is used from the next read.
REQ-028 SHALL accept LAST changes at any cycle, taking effect on the next next_idx evaluation.
REQ-029 SHALL keep step_d updating in all modes, so entering MODE 11 with STEP already high causes no advance.
REQ-030 SHALL allow LAST=0: forward and reverse both stay at index 0 and pulse WRAP on every advance.

Reset
REQ-031 SHALL, on an edge with RST=1, set IDX=0, VAL=0, WRAP=0, step_d=0, table[i] = i mod 2^WIDTH.
REQ-032 SHALL give RST priority over WR_EN and adv; a write issued in a reset cycle SHALL be discarded.
REQ-033 SHALL make default-table forward operation after reset behave as a WIDTH-bit binary up-counter wrapping at LAST.

Verification
REQ-034 SHALL verify: reset, MODE=01, CE=1, LAST=15, default table -> VAL 0,1,...,15,0; WRAP=1 only in the cycle VAL returns to 0.
REQ-035 SHALL verify: write table[0..3]=0,7,6,5, LAST=3, reset-free, MODE=01 -> VAL cycles 0,7,6,5,0; LOG_LOGIC leads VAL by one step.
REQ-036 SHALL verify: CE=0 mid-run at VAL=6 -> VAL, IDX hold; LOG_SWITCHING=6; LOG_LOGIC=5.
REQ-037 SHALL verify: MODE=10, LAST=3, from IDX=0 -> IDX 3,2,1,0,3; WRAP pulses on each 0->3 transition.
REQ-038 SHALL verify: MODE=11, STEP held high 5 cycles -> exactly one advance; a second STEP pulse advances once more.
REQ-039 SHALL verify: RST=1 with WR_EN=1 to entry 2 (data 9) mid-run -> IDX=0, VAL=0, WRAP=0; table[2]=2 afterwards.
